// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared mode constants, controller state encoding and
//               select-width helper for the N-channel scanning multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAN  = 2'd1,
        SCAN = 2'd2
    } mux_state_t;

    // Select width never collapses below one bit, even for two channels.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Mode FSM plus round-robin pointer and dwell counter; yields
//               the channel index to capture on the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DWELL = 4,
    parameter int SELW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_cap,
    input  logic            i_en,
    input  logic            i_mode,
    input  logic [SELW-1:0] i_sel,
    output logic [SELW-1:0] o_ch
);

    localparam int              DCW         = $clog2(DWELL) + 1;
    localparam logic [DCW-1:0]  c_DCNT_LAST = DCW'(DWELL - 1);
    localparam logic [SELW-1:0] c_PTR_LAST  = SELW'(N_CH - 1);

    mux_state_t      r_state;
    mux_state_t      w_state_nxt;
    logic [SELW-1:0] r_ptr;
    logic [DCW-1:0]  r_dcnt;
    logic            w_scan_entry;
    logic            w_update;
    logic [SELW-1:0] w_ptr_base;
    logic [DCW-1:0]  w_dcnt_base;

    // A stalled cycle (enabled but unable to capture) freezes everything, so
    // mode changes during a stall only take effect on the next capture.
    assign w_update     = i_cap || !i_en;
    assign w_scan_entry = (r_state != SCAN);
    assign w_ptr_base   = w_scan_entry ? '0 : r_ptr;
    assign w_dcnt_base  = w_scan_entry ? '0 : r_dcnt;
    assign o_ch         = (i_mode == MODE_SCAN) ? w_ptr_base : i_sel;

    always_comb begin
        w_state_nxt = r_state;
        if (!i_en) begin
            w_state_nxt = IDLE;
        end else if (i_mode == MODE_SCAN) begin
            w_state_nxt = SCAN;
        end else begin
            w_state_nxt = MAN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_dcnt  <= '0;
        end else begin
            if (w_update) begin
                r_state <= w_state_nxt;
            end
            // Entry capture counts as the first sample of channel 0's dwell.
            if (i_cap && (i_mode == MODE_SCAN)) begin
                if (w_dcnt_base == c_DCNT_LAST) begin
                    r_dcnt <= '0;
                    r_ptr  <= (w_ptr_base == c_PTR_LAST) ? '0 : w_ptr_base + SELW'(1);
                end else begin
                    r_dcnt <= w_dcnt_base + DCW'(1);
                    r_ptr  <= w_ptr_base;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nx1_scan.sv
`default_nettype none
// ============================================================================
// Module      : mux_nx1_scan
// Description : N-channel, W-bit multiplexer with registered output, manual
//               or round-robin scan channel selection and valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SELW = sel_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [W-1:0]    r_data;
    logic [SELW-1:0] r_ch;
    logic            r_valid;
    logic            w_cap;
    logic [SELW-1:0] w_ch;
    logic [W-1:0]    w_sel_data;

    assign w_cap = en && (!r_valid || out_ready);

    mux_scan_ctrl #(
        .N_CH  (N_CH),
        .DWELL (DWELL),
        .SELW  (SELW)
    ) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_cap  (w_cap),
        .i_en   (en),
        .i_mode (mode),
        .i_sel  (sel),
        .o_ch   (w_ch)
    );

    // An index beyond the last channel matches nothing and yields zero data.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_ch == SELW'(k)) begin
                w_sel_data = in_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
        end else if (w_cap) begin
            r_data  <= w_sel_data;
            r_ch    <= w_ch;
            r_valid <= 1'b1;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready output handshake. Supports two modes. In manual mode the external select picks the channel. In scan mode an internal pointer round-robins all channels, dwelling DWELL accepted samples on each. It sits between several data/sensor sources and a single downstream consumer, and replaces the fixed 4x1 single-bit mux where channel count, width or time-multiplexed sampling is required.

Parameters:
N_CH, 4, number of input channels (>= 2)
W, 1, data width per channel in bits
DWELL, 4, accepted samples taken per channel in scan mode before advancing (>= 1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
in_data  in  N_CH*W  packed channel inputs; channel k occupies bits [k*W +: W]
sel  in  SELW  manual channel select; SELW = max(1, clog2(N_CH))
mode  in  1  0 = manual (sel), 1 = scan (internal pointer)
en  in  1  sample enable; no capture while low
out_data  out  W  registered selected data
out_ch  out  SELW  channel index that out_data came from
out_valid  out  1  out_data/out_ch hold a sample not yet consumed
out_ready  in  1  consumer accepts the sample when out_valid && out_ready

Behaviour:
- Reset (rst_n low, asynchronous): out_data=0, out_ch=0, out_valid=0, scan pointer ptr=0, dwell count dcnt=0, FSM=IDLE. Any in-flight sample is discarded. Reset release takes effect on the first rising clk edge with rst_n high.
- Capture condition, evaluated per clock: cap = en && (!out_valid || out_ready). Latency is 1 cycle: data present at edge t appears on out_data after edge t.
- On cap: out_data <= in_data[ch], out_ch <= ch, out_valid <= 1. Here ch = sel in manual mode and ch = ptr in scan mode.
- Manual mode with sel >= N_CH (possible only when N_CH is not a power of two): out_data <= 0, out_ch <= sel, out_valid <= 1.
- When out_valid && out_ready && !en: out_valid <= 0 and out_data/out_ch hold their values.
- When out_valid && !out_ready: all outputs hold (stall). ptr and dcnt freeze.
- FSM states:
  IDLE: en=0. Go to MAN on en&&!mode, or to SCAN on en&&mode.
  MAN: manual sampling. Go to SCAN on mode=1, or to IDLE on en=0.
  SCAN: scan sampling. Go to MAN on mode=0, or to IDLE on en=0.
- Scan counters, on each cap in SCAN: if dcnt == DWELL-1 then dcnt <= 0 and ptr <= (ptr == N_CH-1) ? 0 : ptr+1. Otherwise dcnt <= dcnt+1.
- Entering SCAN from any state sets ptr <= 0 and dcnt <= 0. The first scan capture happens in the same cycle as entry and uses channel 0.
- mode toggling while stalled: the held sample is unchanged. The FSM transition applies on the next cap-eligible cycle.
- en dropping mid-dwell (going to IDLE) also restarts scan at channel 0 when scanning resumes.
- Widths: dcnt is clog2(DWELL)+1 bits. No arithmetic on data; data is passed through bit-exact.

Decomposition:
- Package mux_pkg: mode constants MODE_MAN=1'b0 and MODE_SCAN=1'b1, the FSM state enum (IDLE, MAN, SCAN), and a SELW helper function.
- Sub-module mux_scan_ctrl: FSM, ptr and dcnt, taking cap/en/mode/sel and producing ch.
- The top level holds the channel slice select and the output/handshake register.

Test Plan:
All scenarios use N_CH=4, W=8, DWELL=2, with in_data = {8'h44, 8'h33, 8'h22, 8'h11}, i.e. channel 0 = 8'h11 ... channel 3 = 8'h44.
1. Reset: rst_n=0 mid-cycle with out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately, without waiting for clk.
2. Manual mode: mode=0, en=1, out_ready=1, sel=2 -> one cycle later out_data=8'h33, out_ch=2, out_valid=1. Changing sel to 0 -> 8'h11 one cycle later.
3. Scan mode: mode=1, en=1, out_ready=1 held for 8 cycles -> out_ch sequence 0,0,1,1,2,2,3,3, then 0,0 (wrap). out_data matches each channel.
4. Backpressure: in scan, drop out_ready for 3 cycles after the first ch1 sample -> out_data holds 8'h22 and out_valid=1. After out_ready returns, the next sample is ch1 (dwell not yet consumed), then ch2.
5. Enable gating: en=0 while out_valid=1 and out_ready=1 -> out_valid=0 next cycle with out_data unchanged. Re-enabling with mode=1 -> restart at ch0.
6. Mode switch mid-dwell: scan at ch2 with dcnt=1, then set mode=0 with sel=3 -> next sample is ch3 (8'h44). Returning to mode=1 -> next sample is ch0.
